// File: rtl/vga_pmod_receiver.sv
// vga_pmod_receiver: TinyVGA PMOD sink (clk, async reset, pmod in; rx_x/rx_y/rx_active/rx_r/rx_g/rx_b, frame_start, line_len, frame_lines, locked, err, frame_crc out) recovering pixels and locking to the timing parameters; VGA_RX_CRC_EN builds the per-frame CRC-16, else frame_crc is 0
module vga_pmod_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_TOTAL = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pmod,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic [1:0]  rx_r,
  output logic [1:0]  rx_g,
  output logic [1:0]  rx_b,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        err,
  output logic [15:0] frame_crc
);
  localparam logic [9:0] HA = 10'(H_ACTIVE);
  localparam logic [9:0] HS = 10'(H_SYNC_START);
  localparam logic [9:0] HL = 10'(H_TOTAL - 1);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VS = 10'(V_SYNC_START);
  localparam logic [9:0] VL = 10'(V_TOTAL - 1);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [2:0] LF = 3'(LOCK_FRAMES);
  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;
  state_t state, nxt;
  logic [7:0] s1;
  logic [1:0] s2;
  logic [5:0] pix;
  logic [10:0] h_cnt;
  logic [9:0] l_cnt;
  logic [2:0] good_cnt, good_nxt;
  logic h_seen, bad, hfall, vfall, x_wrap, line_bad, frame_bad, lose;
  assign hfall = s2[1] & ~s1[7];
  assign vfall = s2[0] & ~s1[3];
  assign x_wrap = !hfall && rx_x == HL;
  assign line_bad = hfall && h_seen && h_cnt != HT;
  assign frame_bad = bad || l_cnt != VT;
  assign lose = line_bad || (vfall && l_cnt != VT) || h_cnt == 11'h7ff;
  assign rx_active = locked && rx_x < HA && rx_y < VA;
  assign {rx_r, rx_g, rx_b} = rx_active ? pix : 6'd0;
  assign frame_start = locked && rx_x == 10'd0 && rx_y == 10'd0;
  always_comb begin
    good_nxt = state == UNLOCKED ? 3'd0 :
               state == CHECK && vfall ? (frame_bad ? 3'd0 : good_cnt + 3'd1) : good_cnt;
    nxt = state == UNLOCKED ? (vfall ? CHECK : UNLOCKED) :
          state == CHECK ? (vfall && good_nxt == LF ? LOCKED : CHECK) :
          (lose ? UNLOCKED : LOCKED);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      pix <= '0;
      rx_x <= '0;
      rx_y <= '0;
      h_cnt <= '0;
      line_len <= '0;
      l_cnt <= '0;
      frame_lines <= '0;
      bad <= 1'b0;
      h_seen <= 1'b0;
      state <= UNLOCKED;
      good_cnt <= '0;
      locked <= 1'b0;
      err <= 1'b0;
    end else begin
      s1 <= pmod;
      s2 <= {s1[7], s1[3]};
      pix <= {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]};
      rx_x <= hfall ? HS : x_wrap ? 10'd0 : rx_x + 10'd1;
      rx_y <= vfall ? VS : x_wrap ? (rx_y == VL ? 10'd0 : rx_y + 10'd1) : rx_y;
      h_cnt <= hfall ? 11'd1 : h_cnt == 11'h7ff ? h_cnt : h_cnt + 11'd1;
      line_len <= hfall ? h_cnt : line_len;
      l_cnt <= vfall ? {9'd0, hfall} : hfall && l_cnt != 10'h3ff ? l_cnt + 10'd1 : l_cnt;
      frame_lines <= vfall ? l_cnt : frame_lines;
      bad <= vfall ? line_bad : bad | line_bad;
      h_seen <= nxt == UNLOCKED && state != UNLOCKED ? 1'b0 : h_seen | hfall;
      state <= nxt;
      good_cnt <= good_nxt;
      locked <= nxt == LOCKED;
      err <= state == LOCKED && nxt == UNLOCKED;
    end
`ifdef VGA_RX_CRC_EN
  logic [15:0] acc;
  logic crc_ok;
  function automatic logic [15:0] crc6(input logic [15:0] c, input logic [5:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 5; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= 16'hffff;
      crc_ok <= 1'b0;
      frame_crc <= '0;
    end else begin
      acc <= !locked ? 16'hffff :
             frame_start ? crc6(16'hffff, {rx_r, rx_g, rx_b}) :
             rx_active ? crc6(acc, {rx_r, rx_g, rx_b}) : acc;
      crc_ok <= locked && (crc_ok || frame_start);
      frame_crc <= frame_start && crc_ok ? acc : frame_crc;
    end
`else
  assign frame_crc = 16'h0000;
`endif
endmodule
